// File: rtl/fp_normalize_round_if.sv
// rtl/fp_normalize_round_if.sv - operand-in / result-out handshake bundle for the FP normalize/round stage
interface fp_normalize_round_if #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_sign;
    logic [EXP_WIDTH-1:0]           in_exponent;
    logic [MAN_WIDTH+3:0]           in_sum;
    logic                           in_sticky;
    logic                           out_valid;
    logic                           out_ready;
    logic [EXP_WIDTH+MAN_WIDTH:0]   out_result;
    logic                           out_overflow;
    logic                           out_underflow;

    modport master (
        output in_valid, in_sign, in_exponent, in_sum, in_sticky, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_sum, in_sticky, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - FP adder normalize + round-to-nearest-even + pack; NORM_LZC_EN selects one-cycle LZC shift
module fp_normalize_round #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic               clk,
    input  logic               reset_n,
    fp_normalize_round_if.slave bus
);
    localparam int SW = MAN_WIDTH + 4;
    localparam int EW = EXP_WIDTH + 1;
    localparam int RW = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_WIDTH{1'b1}}};
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   man_q, man_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic            sticky_q, sticky_d;
    logic            sign_q, sign_d;
    logic [RW-1:0]   result_q, result_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic                 rnd_inc;
    logic [MAN_WIDTH:0]   frac_sum;
    logic [EW-1:0]        exp_rnd;
`ifdef NORM_LZC_EN
    logic [EW-1:0]        lz;
    logic [EW-1:0]        shamt;
    logic [SW-1:0]        man_sh;
`endif

    always_comb begin
        state_d  = state_q;
        man_d    = man_q;
        exp_d    = exp_q;
        sticky_d = sticky_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        // Hidden bit is guaranteed set in ROUND, so only the fraction is incremented;
        // its carry-out means the mantissa rolled over to 2.0.
        rnd_inc  = man_q[1] & (man_q[0] | sticky_q | man_q[2]);
        frac_sum = {1'b0, man_q[SW-3:2]} + (MAN_WIDTH+1)'(rnd_inc);
        exp_rnd  = exp_q + EW'(frac_sum[MAN_WIDTH]);

`ifdef NORM_LZC_EN
        lz = EW'(SW - 1);
        for (int i = 0; i < SW - 1; i++) begin
            if (man_q[i]) lz = EW'(SW - 2 - i);
        end
        // Clamp so the exponent never drops below 1.
        if (exp_q <= EXP_ONE)           shamt = '0;
        else if (lz > exp_q - EXP_ONE)  shamt = exp_q - EXP_ONE;
        else                            shamt = lz;
        man_sh = man_q << shamt;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    man_d    = bus.in_sum;
                    exp_d    = {1'b0, bus.in_exponent};
                    sticky_d = bus.in_sticky;
                    sign_d   = bus.in_sign;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (man_q == '0 && !sticky_q) begin
                    result_d = '0;
                    state_d  = DONE;
                end else if (man_q[SW-1]) begin
                    man_d    = man_q >> 1;
                    sticky_d = sticky_q | man_q[0];
                    exp_d    = exp_q + EXP_ONE;
                    state_d  = ROUND;
                end else if (man_q[SW-2]) begin
                    state_d  = ROUND;
                end else begin
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
`ifdef NORM_LZC_EN
                if (man_sh[SW-2]) begin
                    man_d   = man_sh;
                    exp_d   = exp_q - shamt;
                    state_d = ROUND;
                end else begin
                    result_d = {sign_q, {(RW-1){1'b0}}};
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end
`else
                if (exp_q <= EXP_ONE) begin
                    result_d = {sign_q, {(RW-1){1'b0}}};
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    man_d = man_q << 1;
                    exp_d = exp_q - EXP_ONE;
                    if (man_q[SW-3]) state_d = ROUND;
                end
`endif
            end
            ROUND: begin
                if (exp_rnd >= EXP_MAX) begin
                    result_d = {sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_rnd[EXP_WIDTH-1:0], frac_sum[MAN_WIDTH-1:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            man_q    <= '0;
            exp_q    <= '0;
            sticky_q <= 1'b0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            man_q    <= man_d;
            exp_q    <= exp_d;
            sticky_q <= sticky_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_result    = result_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - directed-vector bench for fp_normalize_round
module tb_fp_normalize_round;
    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_total;

    fp_normalize_round_if #(.EXP_WIDTH(8), .MAN_WIDTH(23)) bus ();

    fp_normalize_round #(.EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic start_op(input logic s, input logic [7:0] e, input logic [26:0] sum, input logic st);
        @(negedge clk);
        bus.in_sign     = s;
        bus.in_exponent = e;
        bus.in_sum      = sum;
        bus.in_sticky   = st;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the transfer edge (the LOAD cycle).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_vld_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic s, input logic [7:0] e, input logic [26:0] sum,
                         input logic st, input logic [31:0] e_res, input logic e_ovf, input logic e_unf,
                         input int e_lat);
        int lat;
        start_op(s, e, sum, st);
        wait_done(lat);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_res"}, bus.out_result, e_res);
        check({tag, "_flags"}, {30'd0, bus.out_overflow, bus.out_underflow}, {30'd0, e_ovf, e_unf});
        if (e_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(e_lat));
        else           check({tag, "_lat_le3"}, 32'(lat <= 3), 32'd1);
        release_result(tag);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_exponent = '0;
        bus.in_sum      = '0;
        bus.in_sticky   = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        check("rst_flags", {30'd0, bus.out_overflow, bus.out_underflow}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op("one_plus_one", 1'b0, 8'd127, 27'h4000000, 1'b0, 32'h40000000, 1'b0, 1'b0, 3);
        do_op("three",        1'b0, 8'd127, 27'h6000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 3);
`ifdef NORM_LZC_EN
        do_op("cancel",       1'b0, 8'd130, 27'h0000004, 1'b0, 32'h35800000, 1'b0, 1'b0, 4);
        do_op("shift2",       1'b0, 8'd127, 27'h0800003, 1'b0, 32'h3E800003, 1'b0, 1'b0, 4);
        do_op("underflow",    1'b0, 8'd3,   27'h0000004, 1'b0, 32'h00000000, 1'b0, 1'b1, 3);
`else
        do_op("cancel",       1'b0, 8'd130, 27'h0000004, 1'b0, 32'h35800000, 1'b0, 1'b0, 26);
        do_op("shift2",       1'b0, 8'd127, 27'h0800003, 1'b0, 32'h3E800003, 1'b0, 1'b0, 5);
        do_op("underflow",    1'b0, 8'd3,   27'h0000004, 1'b0, 32'h00000000, 1'b0, 1'b1, 5);
`endif
        do_op("tie_up",       1'b0, 8'd127, 27'h2000006, 1'b0, 32'h3F800002, 1'b0, 1'b0, 3);
        do_op("tie_even",     1'b0, 8'd127, 27'h200000A, 1'b0, 32'h3F800002, 1'b0, 1'b0, 3);
        do_op("rnd_carry",    1'b0, 8'd127, 27'h3FFFFFE, 1'b1, 32'h40000000, 1'b0, 1'b0, 3);
        do_op("overflow",     1'b0, 8'd254, 27'h6000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3);
        do_op("sticky_rsh",   1'b0, 8'd127, 27'h4000005, 1'b0, 32'h40000001, 1'b0, 1'b0, 3);
        do_op("neg_one",      1'b1, 8'd127, 27'h2000000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 3);
        do_op("zero_neg",     1'b1, 8'd100, 27'h0000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 0);

        // Backpressure: result and handshake state hold while out_ready stays low.
        start_op(1'b0, 8'd127, 27'h2000006, 1'b0);
        wait_done(lat);
        held = bus.out_result;
        check("bp_first", held, 32'h3F800002);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", bus.out_result, 32'h3F800002);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        release_result("bp");

        // Reset asserted while SHIFT is in progress aborts the operation.
        start_op(1'b0, 8'd130, 27'h0000004, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", bus.out_result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) break;
        end
        check("mid_rst_no_output", 32'(bus.out_valid), 32'd0);
        do_op("post_rst", 1'b0, 8'd127, 27'h4000000, 1'b0, 32'h40000000, 1'b0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
